// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback unit for the RV32I core.
// Extracts load data, picks the writeback source, qualifies the write enable and counts retirements.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            EX_MEM_valid,
  input  logic            EX_MEM_RegWrite,
  input  logic [1:0]      EX_MEM_MemtoReg,
  input  logic [4:0]      EX_MEM_RD,
  input  logic [XLEN-1:0] EX_MEM_ALU_Result,
  input  logic [XLEN-1:0] EX_MEM_PC,
  input  logic [2:0]      EX_MEM_funct3,
  input  logic [XLEN-1:0] Mem_RData,
  output logic            MeM_WB_RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] Write_Data,
  output logic            MeM_WB_valid,
  output logic            load_fault,
  output logic [31:0]     retired_count
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Little-endian lane extraction; illegal encodings yield zero so the fault path stays deterministic.
  function automatic logic [31:0] extract_load(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    shifted = word >> {off, 3'b000};
    byte_v  = shifted[7:0];
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (f3)
      3'b000:  extract_load = {{24{byte_v[7]}}, byte_v};
      3'b100:  extract_load = {24'h000000, byte_v};
      3'b001:  extract_load = {{16{half_v[15]}}, half_v};
      3'b101:  extract_load = {16'h0000, half_v};
      3'b010:  extract_load = word;
      default: extract_load = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001, 3'b101: load_misaligned = off[0];
      3'b010:         load_misaligned = (off != 2'b00);
      default:        load_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic load_illegal(input logic [2:0] f3);
    case (f3)
      3'b011, 3'b110, 3'b111: load_illegal = 1'b1;
      default:                load_illegal = 1'b0;
    endcase
  endfunction

  logic [31:0] load_data_s;
  logic [31:0] wb_data_s;
  logic        fault_s;
  logic        wen_s;

  logic        valid_d, valid_q;
  logic        regwrite_d, regwrite_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] wdata_d, wdata_q;
  logic        fault_d, fault_q;
  logic [31:0] count_d, count_q;

  // Writeback value and write-enable qualification for the incoming instruction.
  always_comb begin
    load_data_s = extract_load(EX_MEM_funct3, EX_MEM_ALU_Result[1:0], Mem_RData);
    fault_s     = EX_MEM_valid & (EX_MEM_MemtoReg == WB_LOAD) &
                  (load_misaligned(EX_MEM_funct3, EX_MEM_ALU_Result[1:0]) |
                   load_illegal(EX_MEM_funct3));
    case (EX_MEM_MemtoReg)
      WB_LOAD: wb_data_s = load_data_s;
      WB_PC4:  wb_data_s = EX_MEM_PC + 32'd4;
      WB_ALU:  wb_data_s = EX_MEM_ALU_Result;
      default: wb_data_s = EX_MEM_ALU_Result;
    endcase
    wen_s = EX_MEM_valid & EX_MEM_RegWrite & (EX_MEM_RD != 5'd0) & ~fault_s;
  end

  // Stage register next-state: flush beats stall beats capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    fault_d    = 1'b0;
    count_d    = count_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = 5'd0;
      wdata_d    = 32'h0000_0000;
    end else if (stall) begin
      // Outputs hold, but the fault strobe must not repeat for a held instruction.
      fault_d = 1'b0;
    end else begin
      valid_d    = EX_MEM_valid;
      regwrite_d = wen_s;
      rd_d       = EX_MEM_RD;
      wdata_d    = wb_data_s;
      fault_d    = fault_s;
      if (EX_MEM_valid && !fault_s) begin
        count_d = count_q + 32'd1;
      end else begin
        count_d = count_q;
      end
    end
  end

  // Stage state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wdata_q    <= 32'h0000_0000;
      fault_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign MeM_WB_valid    = valid_q;
  assign MeM_WB_RegWrite = regwrite_q;
  assign RD              = rd_q;
  assign Write_Data      = wdata_q;
  assign load_fault      = fault_q;
  assign retired_count   = count_q;

endmodule
